dcache_line_adapter: RTL and testbench
======================================

DCACHE_LINE_ADAPTER -- requirements
Module: dcache_line_adapter

Interface
REQ-001 clk  input  1  clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 dfp_addr  input  32  cache-side line address; bits [4:0] ignored.
REQ-004 dfp_read  input  1  cache-side line read request, held until dfp_ready.
REQ-005 dfp_write  input  1  cache-side line writeback request, held until dfp_ready.
REQ-006 dfp_wdata  input  256  writeback line data.
REQ-007 dfp_ready  output  1  request accepted this cycle when high with dfp_read or dfp_write.
REQ-008 dfp_raddr  output  32  address of returned line, bits [4:0] = 0.
REQ-009 dfp_rdata  output  256  returned line data.
REQ-010 dfp_rvalid  output  1  one-cycle pulse, line return valid.
REQ-011 bmem_addr  output  32  burst memory address, bits [4:0] = 0.
REQ-012 bmem_read  output  1  burst read command.
REQ-013 bmem_write  output  1  burst write beat valid.
REQ-014 bmem_wdata  output  64  write beat data.
REQ-015 bmem_ready  input  1  memory accepts command/beat this cycle.
REQ-016 bmem_raddr  input  32  address tag of incoming read beat.
REQ-017 bmem_rdata  input  64  read beat data.
REQ-018 bmem_rvalid  input  1  read beat valid.

Function
REQ-019 States: IDLE, WRITE, READ, RESP; one transaction outstanding at a time.
REQ-020 IDLE, dfp_write=1: dfp_ready=1 regardless of bmem_ready; latch {dfp_addr[31:5],5'b0} and dfp_wdata; beat count := 0; go WRITE.
REQ-021 IDLE, dfp_read=1, dfp_write=0: dfp_ready=bmem_ready, bmem_read=1, bmem_addr={dfp_addr[31:5],5'b0} combinationally; on bmem_ready latch address, beat count := 0, go READ; else stay IDLE.
REQ-022 dfp_read and dfp_write both high in IDLE: write has priority; read not accepted that cycle.
REQ-023 dfp_ready=0 in WRITE, READ, RESP.
REQ-024 WRITE: bmem_write=1, bmem_addr=latched address, bmem_wdata=latched line bits [64k+63:64k], k=beat count.
REQ-025 WRITE beat advances only on bmem_ready=1; bmem_ready=0 holds bmem_write, address and data unchanged.
REQ-026 WRITE: 4th accepted beat (k=3 and bmem_ready) -> IDLE; dfp_ready may be high the following cycle.
REQ-027 READ: beat with bmem_rvalid=1 and bmem_raddr[31:5]==latched address[31:5] writes bmem_rdata into line buffer bits [64k+63:64k], k increments; beats with mismatched tag are dropped.
REQ-028 READ: 4th matching beat -> RESP next cycle.
REQ-029 RESP: dfp_rvalid=1 for exactly one cycle, dfp_raddr=latched address, dfp_rdata=assembled line; next state IDLE.
REQ-030 dfp_raddr and dfp_rdata hold last returned values outside RESP; dfp_rvalid=0 outside RESP.
REQ-031 Latency: write accepted cycle T -> beats T+1..T+4 with no stalls; read last beat at cycle T -> dfp_rvalid at T+1.
REQ-032 bmem_read=0 outside IDLE; bmem_write=0 outside WRITE.
REQ-033 Beat counter 2 bits; never wraps within a transaction; cleared on entry to WRITE/READ.
REQ-034 dfp_read/dfp_write deasserting in IDLE before dfp_ready: no command issued, no state change.

Reset
REQ-035 rst=1 at any edge: state := IDLE, beat count := 0, latched address/wdata := 0, line buffer := 0, dfp_raddr := 0, dfp_rdata := 0.
REQ-036 Cycle after reset: dfp_rvalid=0, bmem_read=0 unless a read request is present, bmem_write=0.
REQ-037 Reset mid-WRITE or mid-READ abandons the transaction: no further beats emitted, late bmem_rvalid beats ignored, no dfp_rvalid.

Verification
REQ-038 Read 0x0000_1040, bmem_ready=1, beats 0x11..11,0x22..22,0x33..33,0x44..44 tagged 0x1040 -> one dfp_rvalid, dfp_raddr=0x1040, dfp_rdata={0x44..,0x33..,0x22..,0x11..}.
REQ-039 Write 0x0000_2000, dfp_wdata=beats {D3,D2,D1,D0}, bmem_ready low on 2nd beat for 2 cycles -> bmem_wdata D0,D1,D1,D1,D2,D3 with bmem_write high 6 cycles, then IDLE.
REQ-040 Writeback then read (dfp_write, then dfp_read held through WRITE) -> dfp_ready=0 until 4 write beats done; read command issued the cycle after.
REQ-041 Read 0x3000 with interleaved stray beat tagged 0x4000 -> stray beat dropped; dfp_rdata built from 4 matching beats only.
REQ-042 dfp_read with bmem_ready=0 for 3 cycles -> dfp_ready=0, bmem_read=1 held, state IDLE; accepted on 4th cycle.
REQ-043 rst asserted after 2 read beats -> state IDLE, remaining beats ignored, dfp_rvalid never asserted.

Source files
------------

// File: rtl/dcache_line_adapter.sv
// dcache_line_adapter
// Purpose: adapts 256-bit cache line reads/writebacks on the dfp_* side to
//          4-beat x 64-bit bursts on the bmem_* side. One transaction at a time.
// Latency: a write accepted at cycle T emits beats at T+1..T+4 when memory never
//          stalls. A read returns dfp_rvalid one cycle after its last matching beat.
// Backpressure: bmem_ready stalls write beats and read command issue. A read is
//          accepted only together with its memory command. dfp_ready is low while busy.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   dfp_addr/read/write/wdata     cache-side line request (held until dfp_ready)
//   dfp_ready                     request accepted this cycle
//   dfp_raddr/rdata/rvalid        returned line; rvalid is a one-cycle pulse
//   bmem_addr/read/write/wdata    burst memory command and write beats
//   bmem_ready                    memory accepts command/beat this cycle
//   bmem_raddr/rdata/rvalid       tagged read beats from memory
module dcache_line_adapter (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  dfp_addr,
  input  logic         dfp_read,
  input  logic         dfp_write,
  input  logic [255:0] dfp_wdata,
  output logic         dfp_ready,
  output logic [31:0]  dfp_raddr,
  output logic [255:0] dfp_rdata,
  output logic         dfp_rvalid,
  output logic [31:0]  bmem_addr,
  output logic         bmem_read,
  output logic         bmem_write,
  output logic [63:0]  bmem_wdata,
  input  logic         bmem_ready,
  input  logic [31:0]  bmem_raddr,
  input  logic [63:0]  bmem_rdata,
  input  logic         bmem_rvalid
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]   r_state;
  logic [1:0]   w_state_nxt;
  logic [1:0]   r_cnt;
  logic [31:0]  r_addr;
  logic [255:0] r_wdata;
  logic [255:0] r_line;
  logic [31:0]  r_raddr;
  logic [255:0] r_rdata;

  logic [31:0]  w_line_addr;
  logic         w_tag_hit;
  logic         w_rd_accept;
  logic [255:0] w_line_upd;
  logic         w_unused_bits;

  // Line offset bits are ignored on both the request and the beat tag.
  assign w_line_addr   = {dfp_addr[31:5], 5'b0};
  assign w_unused_bits = ^{dfp_addr[4:0], bmem_raddr[4:0]};

  // Beats tagged with a different line are strays and are dropped.
  assign w_tag_hit   = bmem_rvalid && (bmem_raddr[31:5] == r_addr[31:5]);
  // Write wins when both requests are present.
  assign w_rd_accept = dfp_read && !dfp_write && bmem_ready;

  // Line buffer with the current beat slotted in at position r_cnt.
  always_comb begin
    w_line_upd = r_line;
    w_line_upd[{r_cnt, 6'b0} +: 64] = bmem_rdata;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (dfp_write) begin
          w_state_nxt = S_WRITE;
        end else if (w_rd_accept) begin
          w_state_nxt = S_READ;
        end
      end
      S_WRITE: begin
        if (bmem_ready && (r_cnt == 2'd3)) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_READ: begin
        if (w_tag_hit && (r_cnt == 2'd3)) begin
          w_state_nxt = S_RESP;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Outputs.
  always_comb begin
    dfp_ready  = 1'b0;
    bmem_read  = 1'b0;
    bmem_write = 1'b0;
    bmem_addr  = r_addr;
    bmem_wdata = r_wdata[{r_cnt, 6'b0} +: 64];
    dfp_rvalid = 1'b0;
    dfp_raddr  = r_raddr;
    dfp_rdata  = r_rdata;
    case (r_state)
      S_IDLE: begin
        // The read command goes out straight from the request so memory can
        // accept it in the same cycle; the writeback needs no handshake here.
        bmem_addr = w_line_addr;
        bmem_read = dfp_read && !dfp_write;
        dfp_ready = dfp_write || w_rd_accept;
      end
      S_WRITE: begin
        bmem_write = 1'b1;
      end
      S_RESP: begin
        dfp_rvalid = 1'b1;
      end
      default: begin
        bmem_write = 1'b0;
      end
    endcase
  end

  // Datapath: latched request, beat counter, line assembly, returned line.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= 2'd0;
      r_addr  <= 32'd0;
      r_wdata <= 256'd0;
      r_line  <= 256'd0;
      r_raddr <= 32'd0;
      r_rdata <= 256'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (dfp_write) begin
            r_addr  <= w_line_addr;
            r_wdata <= dfp_wdata;
            r_cnt   <= 2'd0;
          end else if (w_rd_accept) begin
            r_addr <= w_line_addr;
            r_cnt  <= 2'd0;
          end
        end
        S_WRITE: begin
          // Counter parks at 3 on the final beat; it is cleared on next entry.
          if (bmem_ready && (r_cnt != 2'd3)) begin
            r_cnt <= r_cnt + 2'd1;
          end
        end
        S_READ: begin
          if (w_tag_hit) begin
            r_line <= w_line_upd;
            if (r_cnt == 2'd3) begin
              // Publish the finished line so it is visible during RESP and
              // held afterwards.
              r_rdata <= w_line_upd;
              r_raddr <= r_addr;
            end else begin
              r_cnt <= r_cnt + 2'd1;
            end
          end
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_line_adapter.sv
module tb_dcache_line_adapter;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  dfp_addr;
  logic         dfp_read;
  logic         dfp_write;
  logic [255:0] dfp_wdata;
  logic         dfp_ready;
  logic [31:0]  dfp_raddr;
  logic [255:0] dfp_rdata;
  logic         dfp_rvalid;
  logic [31:0]  bmem_addr;
  logic         bmem_read;
  logic         bmem_write;
  logic [63:0]  bmem_wdata;
  logic         bmem_ready;
  logic [31:0]  bmem_raddr;
  logic [63:0]  bmem_rdata;
  logic         bmem_rvalid;

  always #5 clk = ~clk;

  dcache_line_adapter dut (
    .clk(clk), .rst(rst),
    .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_write(dfp_write),
    .dfp_wdata(dfp_wdata), .dfp_ready(dfp_ready), .dfp_raddr(dfp_raddr),
    .dfp_rdata(dfp_rdata), .dfp_rvalid(dfp_rvalid),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
    .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Last line the adapter returned; dfp_raddr/dfp_rdata must hold it.
  logic [255:0] last_line = '0;
  logic [31:0]  last_addr = '0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [255:0] rnd256();
    return {rnd64(), rnd64(), rnd64(), rnd64()};
  endfunction

  task automatic idle_checks(input string tag);
    check({tag, "_rvalid"}, 256'(dfp_rvalid), 256'(0));
    check({tag, "_rdata"}, dfp_rdata, last_line);
    check({tag, "_raddr"}, 256'(dfp_raddr), 256'(last_addr));
    check({tag, "_ready"}, 256'(dfp_ready), 256'(0));
  endtask

  task automatic do_reset_tail(input string tag);
    last_line = '0;
    last_addr = '0;
    for (int i = 0; i < 3; i++) begin
      #1;
      idle_checks(tag);
      check({tag, "_bwrite"}, 256'(bmem_write), 256'(0));
      check({tag, "_bread"}, 256'(bmem_read), 256'(0));
      tick();
    end
  endtask

  // Writeback: stall_n cycles of bmem_ready=0 on beat stall_k, or random stalls.
  task automatic do_write(input logic [31:0] addr, input logic [255:0] data,
                          input int stall_k, input int stall_n, input bit rnd_stall,
                          input bit with_read, input bit rst_mid);
    int k;
    int stalls;
    int cyc;
    bit rdy;
    logic [31:0] line_addr;
    line_addr = {addr[31:5], 5'b0};
    dfp_write  = 1'b1;
    dfp_read   = with_read;
    dfp_addr   = addr;
    dfp_wdata  = data;
    bmem_ready = 1'($urandom_range(0, 1));
    #1;
    check("wr_accept_ready", 256'(dfp_ready), 256'(1));
    check("wr_accept_noread", 256'(bmem_read), 256'(0));
    tick();
    dfp_write = 1'b0;
    dfp_wdata = rnd256();
    if (!with_read) dfp_addr = $urandom;
    k = 0; stalls = 0; cyc = 0;
    while (k < 4 && cyc < 100) begin
      if (rst_mid && k == 2) break;
      rdy = rnd_stall ? ($urandom_range(0, 2) != 0) : !(k == stall_k && stalls < stall_n);
      if (!rdy) stalls++;
      bmem_ready = rdy;
      #1;
      check("wr_bwrite", 256'(bmem_write), 256'(1));
      check("wr_baddr", 256'(bmem_addr), 256'(line_addr));
      check("wr_bwdata", 256'(bmem_wdata), 256'(data[64*k +: 64]));
      check("wr_bread", 256'(bmem_read), 256'(0));
      idle_checks("wr_busy");
      tick();
      cyc++;
      if (rdy) k++;
    end
    if (rst_mid) begin
      rst = 1'b1;
      bmem_ready = 1'b1;
      tick();
      rst = 1'b0;
      do_reset_tail("wr_rst");
    end else begin
      check("wr_beats_done", 256'(k), 256'(4));
      check("wr_beat_cycles", 256'(cyc), 256'(4 + stalls));
      #1;
      check("wr_end_bwrite", 256'(bmem_write), 256'(0));
    end
  endtask

  // Line read: n_wait cycles of command backpressure, n_stray foreign beats.
  task automatic do_read(input logic [31:0] addr, input int n_wait, input int n_stray,
                         input bit use_fixed, input logic [255:0] fixed, input bit rst_mid);
    logic [31:0]  tags[$];
    logic [63:0]  dats[$];
    bit           hit[$];
    logic [255:0] exp_line;
    logic [31:0]  line_addr;
    logic [26:0]  x;
    int m;
    int strays;
    line_addr = {addr[31:5], 5'b0};
    dfp_read  = 1'b1;
    dfp_write = 1'b0;
    dfp_addr  = addr;
    for (int i = 0; i < n_wait; i++) begin
      bmem_ready = 1'b0;
      #1;
      check("rd_wait_ready", 256'(dfp_ready), 256'(0));
      check("rd_wait_bread", 256'(bmem_read), 256'(1));
      check("rd_wait_baddr", 256'(bmem_addr), 256'(line_addr));
      tick();
    end
    bmem_ready = 1'b1;
    #1;
    check("rd_accept_ready", 256'(dfp_ready), 256'(1));
    check("rd_accept_bread", 256'(bmem_read), 256'(1));
    check("rd_accept_baddr", 256'(bmem_addr), 256'(line_addr));
    tick();
    dfp_read   = 1'b0;
    dfp_addr   = $urandom;
    bmem_ready = 1'($urandom_range(0, 1));
    // Build the beat stream: matching beats in order, strays interleaved.
    m = 0; strays = n_stray; exp_line = '0;
    while (m < 4) begin
      if (strays > 0 && $urandom_range(0, 1) == 1) begin
        x = 27'($urandom);
        if (x == 0) x = 27'd1;
        tags.push_back({line_addr[31:5] ^ x, 5'($urandom)});
        dats.push_back(rnd64());
        hit.push_back(1'b0);
        strays--;
      end else begin
        tags.push_back({line_addr[31:5], 5'($urandom)});
        dats.push_back(use_fixed ? fixed[64*m +: 64] : rnd64());
        exp_line[64*m +: 64] = dats[$];
        hit.push_back(1'b1);
        m++;
      end
    end
    m = 0;
    foreach (tags[i]) begin
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        bmem_rvalid = 1'b0;
        bmem_raddr  = line_addr;
        bmem_rdata  = rnd64();
        #1;
        idle_checks("rd_gap");
        tick();
      end
      bmem_rvalid = 1'b1;
      bmem_raddr  = tags[i];
      bmem_rdata  = dats[i];
      #1;
      if (rst_mid && m == 2) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        last_line = '0;
        last_addr = '0;
        #1;
        idle_checks("rd_rst_late");
        tick();
        bmem_rvalid = 1'b0;
        do_reset_tail("rd_rst");
        return;
      end
      idle_checks("rd_beat");
      check("rd_beat_bread", 256'(bmem_read), 256'(0));
      check("rd_beat_bwrite", 256'(bmem_write), 256'(0));
      tick();
      if (hit[i]) m++;
    end
    bmem_rvalid = 1'b0;
    #1;
    check("rd_resp_rvalid", 256'(dfp_rvalid), 256'(1));
    check("rd_resp_raddr", 256'(dfp_raddr), 256'(line_addr));
    check("rd_resp_rdata", dfp_rdata, exp_line);
    check("rd_resp_ready", 256'(dfp_ready), 256'(0));
    if (use_fixed) check("rd_resp_fixed", dfp_rdata, fixed);
    last_line = exp_line;
    last_addr = line_addr;
    tick();
    idle_checks("rd_after");
  endtask

  initial begin
    logic [255:0] d;
    rst = 1'b1;
    dfp_addr = '0; dfp_read = 1'b0; dfp_write = 1'b0; dfp_wdata = '0;
    bmem_ready = 1'b0; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    idle_checks("reset");
    check("reset_bread", 256'(bmem_read), 256'(0));
    check("reset_bwrite", 256'(bmem_write), 256'(0));
    tick();

    // Known-beat read.
    d = {64'h4444444444444444, 64'h3333333333333333,
         64'h2222222222222222, 64'h1111111111111111};
    do_read(32'h0000_1040, 0, 0, 1'b1, d, 1'b0);

    // Writeback with two stall cycles on the second beat.
    do_write(32'h0000_2000, rnd256(), 1, 2, 1'b0, 1'b0, 1'b0);

    // Write with a read held alongside (write wins), read issued right after.
    do_write(32'h0000_5000, rnd256(), 0, 0, 1'b1, 1'b1, 1'b0);
    do_read(32'h0000_5000, 0, 0, 1'b0, '0, 1'b0);

    // Stray beat dropped; command backpressure for three cycles.
    do_read(32'h0000_3000, 0, 1, 1'b0, '0, 1'b0);
    do_read(32'h0000_7008, 3, 0, 1'b0, '0, 1'b0);

    // Read request withdrawn before acceptance: no state change.
    dfp_read = 1'b1; bmem_ready = 1'b0; dfp_addr = 32'h0000_9000;
    #1;
    check("wd_bread", 256'(bmem_read), 256'(1));
    check("wd_ready", 256'(dfp_ready), 256'(0));
    tick();
    dfp_read = 1'b0;
    #1;
    check("wd_bread_off", 256'(bmem_read), 256'(0));
    idle_checks("wd");
    tick();

    // Resets in the middle of transactions.
    do_read(32'h0000_A000, 0, 0, 1'b0, '0, 1'b1);
    do_write(32'h0000_B000, rnd256(), 0, 0, 1'b1, 1'b0, 1'b1);
    do_read(32'h0000_C000, 1, 1, 1'b0, '0, 1'b0);

    // Random mix.
    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(0, 1) == 1) begin
        do_write($urandom, rnd256(), 0, 0, 1'b1, 1'b0, 1'b0);
      end else begin
        do_read($urandom, $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, '0, 1'b0);
      end
      bmem_ready = 1'($urandom_range(0, 1));
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        #1;
        idle_checks("rnd_idle");
        check("rnd_idle_bwrite", 256'(bmem_write), 256'(0));
        tick();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
